// File: rtl/rib_ram_responder.sv
// rib_ram_responder: 32-bit word RAM slave on the RIB request/ack bus.
// An accepted request spends two cycles in ACCESS. The first cycle registers
// the range check and word index. The second cycle performs the array
// operation on its exiting edge. RESP then presents a one-cycle ack.
// Optional feature macro RIB_RAM_WAIT_EN inserts one WAIT state between ACCESS
// and RESP. While in WAIT the read data is held in a register.
module rib_ram_responder #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ack_o,
    output logic        err_o,
    output logic        hold_o
);
    localparam int unsigned AW = (DEPTH_WORDS > 32'd1) ? $clog2(DEPTH_WORDS) : 32'd1;
    localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS * 32'd4);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
`ifdef RIB_RAM_WAIT_EN
        ST_WAIT   = 2'd2,
`endif
        ST_RESP   = 2'd3
    } state_t;

    state_t          state_q, state_d;

    // Captured request and decoded address
    logic            we_q, we_d;
    logic [31:0]     addr_q, addr_d;
    logic [3:0]      sel_q, sel_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [AW-1:0]   word_q, word_d;
    logic            in_range_q, in_range_d;
    logic            phase_q, phase_d;   // 0: decode cycle, 1: array cycle of ACCESS
`ifdef RIB_RAM_WAIT_EN
    logic [31:0]     rdata_q, rdata_d;   // read data parked across WAIT
`endif

    // Registered outputs
    logic [31:0]     data_q, data_d;
    logic            ack_q, ack_d;
    logic            err_q, err_d;
    logic            hold_q, hold_d;

    logic [31:0]     off_s;
    logic [31:0]     rd_value_s;
    logic            mem_we_s;

    logic [31:0]     ram_array [DEPTH_WORDS];

    // Byte offset from the window base. Unsigned wrap makes addresses below
    // the base look huge, so they fail the range check.
    assign off_s = addr_q - BASE_ADDR;

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Reset forces IDLE, which aborts any in-flight access.
    always_comb begin
        state_d = state_q;
        if (!rst) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_i) begin
                        state_d = ST_ACCESS;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (phase_q) begin
`ifdef RIB_RAM_WAIT_EN
                        state_d = ST_WAIT;
`else
                        state_d = ST_RESP;
`endif
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end
`ifdef RIB_RAM_WAIT_EN
                ST_WAIT: state_d = ST_RESP;
`endif
                ST_RESP: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Request capture in IDLE and address decode in the first ACCESS cycle
    always_comb begin
        we_d       = we_q;
        addr_d     = addr_q;
        sel_d      = sel_q;
        wdata_d    = wdata_q;
        word_d     = word_q;
        in_range_d = in_range_q;
        phase_d    = 1'b0;
        if ((state_q == ST_IDLE) && req_i) begin
            we_d    = we_i;
            addr_d  = addr_i;
            sel_d   = sel_i;
            wdata_d = data_i;
        end else begin
            we_d    = we_q;
        end
        if ((state_q == ST_ACCESS) && !phase_q) begin
            phase_d    = 1'b1;
            word_d     = off_s[AW+1:2];
            in_range_d = (off_s < SPAN_BYTES);
        end else begin
            phase_d    = 1'b0;
        end
    end

    // Output logic: array strobe, read mux and next values of the registered outputs
    always_comb begin
        mem_we_s   = 1'b0;
        rd_value_s = 32'h0000_0000;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        data_d     = 32'h0000_0000;
        hold_d     = (state_d != ST_IDLE);
`ifdef RIB_RAM_WAIT_EN
        rdata_d    = rdata_q;
`endif
        // Out-of-range reads and all writes return zero data
        if (!we_q && in_range_q) begin
            rd_value_s = ram_array[word_q];
        end else begin
            rd_value_s = 32'h0000_0000;
        end
        // Array operation on the ACCESS exit edge. Reset on that same edge
        // suppresses the write.
        if ((state_q == ST_ACCESS) && phase_q && rst) begin
            mem_we_s = we_q && in_range_q;
`ifdef RIB_RAM_WAIT_EN
            rdata_d  = rd_value_s;
`endif
        end else begin
            mem_we_s = 1'b0;
        end
        if (state_d == ST_RESP) begin
            ack_d = 1'b1;
            err_d = ~in_range_q;
`ifdef RIB_RAM_WAIT_EN
            data_d = rdata_q;
`else
            data_d = rd_value_s;
`endif
        end else begin
            ack_d  = 1'b0;
            err_d  = 1'b0;
            data_d = 32'h0000_0000;
        end
    end

    // Request, decode and output registers, all cleared by reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            we_q       <= 1'b0;
            addr_q     <= 32'h0000_0000;
            sel_q      <= 4'h0;
            wdata_q    <= 32'h0000_0000;
            word_q     <= '0;
            in_range_q <= 1'b0;
            phase_q    <= 1'b0;
`ifdef RIB_RAM_WAIT_EN
            rdata_q    <= 32'h0000_0000;
`endif
            data_q     <= 32'h0000_0000;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            hold_q     <= 1'b0;
        end else begin
            we_q       <= we_d;
            addr_q     <= addr_d;
            sel_q      <= sel_d;
            wdata_q    <= wdata_d;
            word_q     <= word_d;
            in_range_q <= in_range_d;
            phase_q    <= phase_d;
`ifdef RIB_RAM_WAIT_EN
            rdata_q    <= rdata_d;
`endif
            data_q     <= data_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            hold_q     <= hold_d;
        end
    end

    // Storage array: byte-lane writes, contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            if (sel_q[0]) ram_array[word_q][7:0]   <= wdata_q[7:0];
            if (sel_q[1]) ram_array[word_q][15:8]  <= wdata_q[15:8];
            if (sel_q[2]) ram_array[word_q][23:16] <= wdata_q[23:16];
            if (sel_q[3]) ram_array[word_q][31:24] <= wdata_q[31:24];
        end
    end

    assign data_o = data_q;
    assign ack_o  = ack_q;
    assign err_o  = err_q;
    assign hold_o = hold_q;

endmodule

// File: tb/tb_rib_ram_responder.sv
// Scoreboard testbench for rib_ram_responder (DEPTH_WORDS = 4096, default base).
// Stimulus pushes the expected ack into a queue. A negedge monitor pops the
// queue and compares each entry against the ack it belongs to.
module tb_rib_ram_responder;
`ifdef RIB_RAM_WAIT_EN
    localparam int EXP_LAT = 3;   // request edge to ack cycle, in edges
    localparam int PERIOD  = 5;   // back-to-back acceptance spacing
`else
    localparam int EXP_LAT = 2;
    localparam int PERIOD  = 4;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [3:0]  sel_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        ack_o;
    logic        err_o;
    logic        hold_o;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
        int          acc_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   checks    = 0;
    int   errors    = 0;
    int   cyc       = 0;
    int   ack_count = 0;
    logic mon_en    = 1'b0;

    rib_ram_responder #(
        .DEPTH_WORDS (4096),
        .BASE_ADDR   (32'h1000_0000)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req_i  (req_i),
        .we_i   (we_i),
        .addr_i (addr_i),
        .sel_i  (sel_i),
        .data_i (data_i),
        .data_o (data_o),
        .ack_o  (ack_o),
        .err_o  (err_o),
        .hold_o (hold_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every ack must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (mon_en) begin
            if (ack_o === 1'b1) begin
                ack_count++;
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: actual ack=1 expected no ack (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("ack_data", data_o, e.data);
                    check("ack_err", {31'd0, err_o}, {31'd0, e.err});
                    check("ack_latency", 32'(cyc - e.acc_cyc), 32'(EXP_LAT));
                    check("ack_hold", {31'd0, hold_o}, 32'd1);
                end
            end else begin
                check("idle_data", data_o, 32'h0);
                check("idle_err", {31'd0, err_o}, 32'd0);
            end
        end
    end

    // Wait for IDLE with a bound; a timeout counts as a failed comparison
    task automatic wait_idle();
        int n;
        n = 0;
        while (hold_o !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (hold_o !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: actual hold=%b expected 0", hold_o);
        end
    endtask

    // One request: drive, push expectation on acceptance, then scramble inputs
    task automatic access(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                          input logic [31:0] wdata, input logic [31:0] exp_data, input logic exp_err);
        exp_t e;
        @(negedge clk);
        wait_idle();
        req_i  = 1'b1;
        we_i   = we;
        addr_i = addr;
        sel_i  = sel;
        data_i = wdata;
        @(posedge clk);
        #1;
        e.data    = exp_data;
        e.err     = exp_err;
        e.acc_cyc = cyc;
        sb_q.push_back(e);
        req_i  = 1'b0;
        we_i   = ~we;
        addr_i = $urandom;
        sel_i  = 4'($urandom);
        data_i = $urandom;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acks_before;
        exp_t e;
        rst    = 1'b0;
        req_i  = 1'b0;
        we_i   = 1'b0;
        addr_i = 32'h0;
        sel_i  = 4'h0;
        data_i = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ack",  {31'd0, ack_o},  32'd0);
        check("reset_err",  {31'd0, err_o},  32'd0);
        check("reset_hold", {31'd0, hold_o}, 32'd0);
        check("reset_data", data_o, 32'h0);
        mon_en = 1'b1;
        @(negedge clk);
        rst = 1'b1;

        // Full-word write, read back; address low bits and read sel ignored
        access(1'b1, 32'h1000_0010, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0);
        access(1'b0, 32'h1000_0010, 4'hF, 32'h0,         32'hDEAD_BEEF, 1'b0);
        // Single-lane write merges into the existing word
        access(1'b1, 32'h1000_0010, 4'b0001, 32'h0000_00AA, 32'h0, 1'b0);
        access(1'b0, 32'h1000_0010, 4'hF, 32'h0,         32'hDEAD_BEAA, 1'b0);
        // sel = 0 write leaves memory alone and acks cleanly
        access(1'b1, 32'h1000_0010, 4'h0, 32'h1111_1111, 32'h0, 1'b0);
        access(1'b0, 32'h1000_0013, 4'h0, 32'h0,         32'hDEAD_BEAA, 1'b0);
        // Word 0 and last word of the window
        access(1'b1, 32'h1000_0000, 4'hF, 32'h1122_3344, 32'h0, 1'b0);
        access(1'b1, 32'h1000_3FFC, 4'hF, 32'h5A5A_5A5A, 32'h0, 1'b0);
        access(1'b0, 32'h1000_3FFC, 4'hF, 32'h0,         32'h5A5A_5A5A, 1'b0);
        // Out of range below and above; the write above would alias word 0
        access(1'b0, 32'h0FFF_FFFC, 4'hF, 32'h0,         32'h0, 1'b1);
        access(1'b0, 32'h1000_4000, 4'hF, 32'h0,         32'h0, 1'b1);
        access(1'b1, 32'h1000_4000, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b1);
        access(1'b1, 32'h0FFF_FFFC, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b1);
        access(1'b0, 32'h1000_0000, 4'hF, 32'h0,         32'h1122_3344, 1'b0);
        access(1'b0, 32'h1000_3FFC, 4'hF, 32'h0,         32'h5A5A_5A5A, 1'b0);

        // Continuous request for 12 edges: one acceptance every PERIOD edges
        @(negedge clk);
        wait_idle();
        acks_before = ack_count;
        req_i  = 1'b1;
        we_i   = 1'b0;
        addr_i = 32'h1000_0010;
        sel_i  = 4'hF;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if ((i % PERIOD) == 0) begin
                e.data    = 32'hDEAD_BEAA;
                e.err     = 1'b0;
                e.acc_cyc = cyc;
                sb_q.push_back(e);
            end
            check("burst_hold", {31'd0, hold_o}, ((i % PERIOD) == PERIOD - 1) ? 32'd0 : 32'd1);
        end
        req_i = 1'b0;
        repeat (8) @(negedge clk);
        check("burst_ack_count", 32'(ack_count - acks_before), 32'd3);

        // Reset on the ACCESS exit edge of a write: no ack, no write
        access(1'b1, 32'h1000_0020, 4'hF, 32'hCAFE_F00D, 32'h0, 1'b0);
        access(1'b0, 32'h1000_0020, 4'hF, 32'h0,         32'hCAFE_F00D, 1'b0);
        @(negedge clk);
        wait_idle();
        req_i  = 1'b1;
        we_i   = 1'b1;
        addr_i = 32'h1000_0020;
        sel_i  = 4'hF;
        data_i = 32'h1234_5678;
        @(posedge clk);
        #1;
        req_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("abort_ack",  {31'd0, ack_o},  32'd0);
        check("abort_err",  {31'd0, err_o},  32'd0);
        check("abort_hold", {31'd0, hold_o}, 32'd0);
        check("abort_data", data_o, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        access(1'b0, 32'h1000_0020, 4'hF, 32'h0, 32'hCAFE_F00D, 1'b0);

        repeat (10) @(negedge clk);
        check("all_acks_seen", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
